// File: rtl/rtmc_pkg.sv
// Shared types and constants for the rtmc SPI slave front end.
package rtmc_pkg;

    localparam int unsigned SPI_BYTE_W = 8;
    localparam int unsigned CMD_WR_BIT = 7;
    localparam int unsigned BIT_CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        WDATA = 2'd2,
        RDATA = 2'd3
    } spi_state_e;

endpackage

// File: rtl/rtmc_sync.sv
// N-flop single-bit synchronizer with a selectable reset value.
module rtmc_sync #(
    parameter int unsigned N       = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= {N{RST_VAL}};
        end else begin
            sr <= {sr[N-2:0], d};
        end
    end

    assign q = sr[N-1];

endmodule

// File: rtl/rtmc_spi_slave.sv
// SPI mode-0 slave: pin sync, command/data deframing, register-file strobes, sdo shift-out.
// Define RTMC_SPI_AUTOINC_EN to auto-increment the register address across burst bytes.
module rtmc_spi_slave
    import rtmc_pkg::*;
#(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sck,
    input  logic                  cs_n,
    input  logic                  sdi,
    output logic                  sdo,
    output logic [ADDR_W-1:0]     reg_addr,
    output logic [SPI_BYTE_W-1:0] reg_wdata,
    output logic                  reg_we,
    output logic                  reg_re,
    input  logic [SPI_BYTE_W-1:0] reg_rdata,
    output logic                  busy
);

`ifdef RTMC_SPI_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic sck_s, cs_n_s, sdi_s, sck_d;
    logic [SYNC_STAGES-1:0] settle_sr;
    logic settled, rise, fall, boundary;

    spi_state_e state, state_n;
    logic [SPI_BYTE_W-1:0] rx, rx_n, tx, tx_n, rd_byte, rd_byte_n, rx_shift;
    logic [BIT_CNT_W-1:0]  bit_cnt, bit_cnt_n;
    logic [ADDR_W-1:0]     addr, addr_n, reg_addr_n;
    logic [SPI_BYTE_W-1:0] reg_wdata_n;
    logic armed, armed_n, load_q, load_n, data_seen, data_seen_n;
    logic reg_we_n, reg_re_n, sdo_n, busy_n;

    rtmc_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck  (.clk(clk), .rst_n(rst_n), .d(sck),  .q(sck_s));
    rtmc_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (.clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_n_s));
    rtmc_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi  (.clk(clk), .rst_n(rst_n), .d(sdi),  .q(sdi_s));

    // cs_n_s shows its reset value until the pipeline fills; only trust it once settled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_sr <= '0;
            sck_d     <= 1'b0;
        end else begin
            settle_sr <= {settle_sr[SYNC_STAGES-2:0], 1'b1};
            sck_d     <= sck_s;
        end
    end

    assign settled  = settle_sr[SYNC_STAGES-1];
    assign rise     = sck_s & ~sck_d;
    assign fall     = ~sck_s & sck_d;
    assign rx_shift = {rx[SPI_BYTE_W-2:0], sdi_s};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rx        <= '0;
            tx        <= '0;
            rd_byte   <= '0;
            bit_cnt   <= '0;
            addr      <= '0;
            armed     <= 1'b0;
            load_q    <= 1'b0;
            data_seen <= 1'b0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            sdo       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            rx        <= rx_n;
            tx        <= tx_n;
            rd_byte   <= rd_byte_n;
            bit_cnt   <= bit_cnt_n;
            addr      <= addr_n;
            armed     <= armed_n;
            load_q    <= load_n;
            data_seen <= data_seen_n;
            reg_we    <= reg_we_n;
            reg_re    <= reg_re_n;
            reg_addr  <= reg_addr_n;
            reg_wdata <= reg_wdata_n;
            sdo       <= sdo_n;
            busy      <= busy_n;
        end
    end

    always_comb begin
        state_n     = state;
        rx_n        = rx;
        tx_n        = tx;
        rd_byte_n   = rd_byte;
        bit_cnt_n   = bit_cnt;
        addr_n      = addr;
        armed_n     = armed;
        load_n      = 1'b0;
        data_seen_n = data_seen;
        reg_we_n    = 1'b0;
        reg_re_n    = 1'b0;
        reg_addr_n  = reg_addr;
        reg_wdata_n = reg_wdata;
        boundary    = 1'b0;

        if (settled && cs_n_s) begin
            armed_n = 1'b1;
        end

        // read data arrives the cycle after the reg_re strobe
        if (reg_re) begin
            load_n = 1'b1;
        end
        if (load_q) begin
            tx_n      = reg_rdata;
            rd_byte_n = reg_rdata;
        end

        if (state != IDLE) begin
            if (rise) begin
                rx_n      = rx_shift;
                bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
                boundary  = (bit_cnt == BIT_CNT_W'(SPI_BYTE_W - 1));
            end else if (fall && (bit_cnt != '0)) begin
                tx_n = {tx[SPI_BYTE_W-2:0], 1'b0};
            end
        end

        case (state)
            IDLE: begin
                if (armed && !cs_n_s) begin
                    state_n = CMD;
                end
            end
            CMD: begin
                if (boundary) begin
                    addr_n = rx_shift[ADDR_W-1:0];
                    if (rx_shift[CMD_WR_BIT]) begin
                        state_n = WDATA;
                    end else begin
                        state_n    = RDATA;
                        reg_re_n   = 1'b1;
                        reg_addr_n = rx_shift[ADDR_W-1:0];
                    end
                end
            end
            WDATA: begin
                if (boundary && (AUTOINC || !data_seen)) begin
                    reg_we_n    = 1'b1;
                    reg_addr_n  = addr;
                    reg_wdata_n = rx_shift;
                    data_seen_n = 1'b1;
                    if (AUTOINC) begin
                        addr_n = addr + ADDR_W'(1);
                    end
                end
            end
            RDATA: begin
                if (boundary) begin
                    if (AUTOINC) begin
                        reg_re_n   = 1'b1;
                        reg_addr_n = addr + ADDR_W'(1);
                        addr_n     = addr + ADDR_W'(1);
                    end else begin
                        tx_n = rd_byte;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // deselect aborts the frame; a strobe decided above this cycle still goes out
        if (cs_n_s) begin
            state_n     = IDLE;
            rx_n        = '0;
            tx_n        = '0;
            bit_cnt_n   = '0;
            data_seen_n = 1'b0;
            load_n      = 1'b0;
        end

        busy_n = (state_n != IDLE);
        sdo_n  = busy_n & tx_n[SPI_BYTE_W-1];
    end

endmodule

// File: tb/tb_rtmc_spi_slave.sv
// Self-checking bench for rtmc_spi_slave: directed vector table, abort/reset sequences, random frames.
// Honours RTMC_SPI_AUTOINC_EN in its reference model.
module tb_rtmc_spi_slave;

`ifdef RTMC_SPI_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif
    localparam int HC = 13;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck = 1'b0;
    logic       cs_n = 1'b1;
    logic       sdi = 1'b0;
    logic       sdo;
    logic [3:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we, reg_re, busy;
    logic [7:0] reg_rdata = 8'h00;

    typedef struct {
        bit         we;
        logic [3:0] addr;
        logic [7:0] data;
    } stb_t;

    typedef struct {
        logic [7:0] cmd;
        int         nd;
        logic [7:0] d0, d1, d2;
        int         exp_cnt;
        logic [3:0] exp_addr;
        logic [7:0] exp_data;
    } vec_t;

    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] rom [16];
    logic [7:0] tx_bytes [8];
    logic [7:0] miso [8];
    logic [7:0] exp_miso [8];
    stb_t       got_q [$];
    stb_t       exp_q [$];
    vec_t       vec [4];

    rtmc_spi_slave #(.ADDR_W(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .sdi(sdi), .sdo(sdo),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
        .reg_rdata(reg_rdata), .busy(busy)
    );

    always #10 clk = ~clk;

    // synchronous-read register file
    always @(posedge clk) begin
        if (reg_re) reg_rdata <= rom[reg_addr];
    end

    always @(negedge clk) begin
        if (reg_we || reg_re) begin
            n_checks++;
            if (reg_we && reg_re) begin
                n_fail++;
                $display("FAIL strobe_exclusive: reg_we=%0b reg_re=%0b, required not both", reg_we, reg_re);
            end
            if (reg_we) got_q.push_back('{1'b1, reg_addr, reg_wdata});
            else        got_q.push_back('{1'b0, reg_addr, 8'h00});
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // master side: sdo sampled just before each rising sck
    task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            sdi = b[i];
            wait_clk(HC);
            r[i] = sdo;
            sck = 1'b1;
            wait_clk(HC);
            sck = 1'b0;
        end
    endtask

    task automatic run_frame(input int nb, input int gap);
        logic [7:0] r;
        got_q.delete();
        cs_n = 1'b0;
        wait_clk(HC);
        check("busy_in_frame", 32'(busy), 32'd1);
        for (int k = 0; k < nb; k++) begin
            spi_bits(tx_bytes[k], 8, r);
            miso[k] = r;
        end
        wait_clk(HC);
        cs_n = 1'b1;
        wait_clk(gap);
        check("busy_after_frame", 32'(busy), 32'd0);
    endtask

    // reference: what a complete frame of cmd + nd data bytes should produce
    task automatic build_expect(input int nd);
        logic [3:0] a;
        a = tx_bytes[0][3:0];
        exp_q.delete();
        if (tx_bytes[0][7]) begin
            for (int k = 0; k < nd; k++)
                if (AUTOINC || k == 0)
                    exp_q.push_back('{1'b1, AUTOINC ? 4'(a + 4'(k)) : a, tx_bytes[k+1]});
        end else begin
            exp_q.push_back('{1'b0, a, 8'h00});
            for (int k = 0; k < nd; k++) begin
                exp_miso[k] = rom[AUTOINC ? 4'(a + 4'(k)) : a];
                if (AUTOINC) exp_q.push_back('{1'b0, 4'(a + 4'(k + 1)), 8'h00});
            end
        end
    endtask

    task automatic compare_frame(input int nd);
        int n;
        check("strobe_count", 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check("strobe_kind", 32'(got_q[i].we), 32'(exp_q[i].we));
            check("strobe_addr", 32'(got_q[i].addr), 32'(exp_q[i].addr));
            check("strobe_wdata", 32'(got_q[i].data), 32'(exp_q[i].data));
        end
        check("sdo_cmd_byte", 32'(miso[0]), 32'd0);
        if (!tx_bytes[0][7])
            for (int k = 0; k < nd; k++) check("sdo_read_byte", 32'(miso[k+1]), 32'(exp_miso[k]));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_sdo"}, 32'(sdo), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_we"}, 32'(reg_we), 32'd0);
        check({tag, "_re"}, 32'(reg_re), 32'd0);
        check({tag, "_addr"}, 32'(reg_addr), 32'd0);
        check({tag, "_wdata"}, 32'(reg_wdata), 32'd0);
    endtask

    initial begin
        logic [7:0] r;
        int nd;

        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
        rom[1] = 8'h96;
        rom[2] = 8'hC3;
        rom[5] = 8'hA7;

        vec[0] = '{8'h83, 1, 8'h5A, 8'h00, 8'h00, 1,               4'h3, 8'h5A};
        vec[1] = '{8'h02, 1, 8'h00, 8'h00, 8'h00, AUTOINC ? 2 : 1, 4'h2, 8'hC3};
        vec[2] = '{8'h8E, 3, 8'h11, 8'h22, 8'h33, AUTOINC ? 3 : 1, 4'hE, 8'h11};
        vec[3] = '{8'h71, 2, 8'h00, 8'h00, 8'h00, AUTOINC ? 3 : 1, 4'h1, 8'h96};

        wait_clk(5);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        wait_clk(5);

        // directed table, 4-clk gap on the first back-to-back pair
        for (int i = 0; i < 4; i++) begin
            tx_bytes[0] = vec[i].cmd;
            tx_bytes[1] = vec[i].d0;
            tx_bytes[2] = vec[i].d1;
            tx_bytes[3] = vec[i].d2;
            build_expect(vec[i].nd);
            run_frame(vec[i].nd + 1, 4 + i);
            compare_frame(vec[i].nd);
            check("vec_cnt", 32'(got_q.size()), 32'(vec[i].exp_cnt));
            check("vec_addr", (got_q.size() > 0) ? 32'(got_q[0].addr) : 32'hFFFF_FFFF, 32'(vec[i].exp_addr));
            if (vec[i].cmd[7])
                check("vec_wdata", (got_q.size() > 0) ? 32'(got_q[0].data) : 32'hFFFF_FFFF, 32'(vec[i].exp_data));
            else
                check("vec_rdata", 32'(miso[1]), 32'(vec[i].exp_data));
        end

        // deselect after 5 bits of the data byte: no write
        got_q.delete();
        cs_n = 1'b0;
        wait_clk(HC);
        spi_bits(8'h81, 8, r);
        spi_bits(8'hFF, 5, r);
        wait_clk(HC);
        cs_n = 1'b1;
        wait_clk(6);
        check("abort_no_strobe", 32'(got_q.size()), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        tx_bytes[0] = 8'h81;
        tx_bytes[1] = 8'h3D;
        build_expect(1);
        run_frame(2, 4);
        compare_frame(1);

        // reset mid-read, then frame stays dead until cs_n toggles
        got_q.delete();
        cs_n = 1'b0;
        wait_clk(HC);
        spi_bits(8'h05, 8, r);
        spi_bits(8'hFF, 3, r);
        check("pre_rst_re", 32'(got_q.size()), 32'd1);
        check("pre_rst_addr", 32'(reg_addr), 32'd5);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        wait_clk(3);
        rst_n = 1'b1;
        got_q.delete();
        spi_bits(8'h85, 8, r);
        spi_bits(8'h3C, 8, r);
        wait_clk(HC);
        check("post_rst_no_strobe", 32'(got_q.size()), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        cs_n = 1'b1;
        wait_clk(6);
        tx_bytes[0] = 8'h85;
        tx_bytes[1] = 8'h3C;
        build_expect(1);
        run_frame(2, 4);
        compare_frame(1);

        // random frames against the reference
        for (int f = 0; f < 20; f++) begin
            nd = int'($urandom_range(1, 3));
            for (int k = 0; k < 4; k++) tx_bytes[k] = 8'($urandom);
            build_expect(nd);
            run_frame(nd + 1, int'($urandom_range(4, 10)));
            compare_frame(nd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
